iso_tx_fifo: RTL
================

ISO_TX_FIFO -- requirements
Module: iso_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, entry count (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush_i  input  1  discard all stored entries.
REQ-006 SHALL have port in_valid_i  input  1  upstream request.
REQ-007 SHALL have port in_ready_o  output  1  FIFO accepts a word this cycle.
REQ-008 SHALL have port in_data_i  input  DATA_WIDTH  upstream payload.
REQ-009 SHALL have port out_valid_o  output  1  request into the downstream 4-phase crossing source port.
REQ-010 SHALL have port out_ready_i  input  1  crossing source ready.
REQ-011 SHALL have port out_data_o  output  DATA_WIDTH  head-of-queue payload.
REQ-012 SHALL have port usage_o  output  $clog2(DEPTH)+1  stored-entry count, 0..DEPTH.
REQ-013 SHALL have ports full_o / empty_o  output  1 each  usage_o==DEPTH / usage_o==0.

Function
REQ-014 Push SHALL occur when in_valid_i && in_ready_o; pop SHALL occur when out_valid_o && out_ready_i.
REQ-015 Storage SHALL be a DEPTH-entry circular buffer with read/write pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-016 usage_o SHALL update +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop.
REQ-017 in_ready_o SHALL equal !full_o && !flush_i; no push when full even if a pop happens the same cycle.
REQ-018 out_valid_o SHALL equal !empty_o (base mode); out_data_o SHALL be the entry at the read pointer.
REQ-019 Base-mode latency SHALL be one cycle: word pushed at edge N is visible on out_valid_o/out_data_o after edge N.
REQ-020 While out_valid_o && !out_ready_i, out_valid_o and out_data_o SHALL remain stable next cycle (except flush/reset).
REQ-021 Simultaneous push and pop at usage 1 SHALL leave usage 1 with the new word at head.
REQ-022 Simultaneous push and pop when empty SHALL NOT occur in base mode (out_valid_o low).
REQ-023 flush_i SHALL, at the next edge, zero both pointers and usage; a push or pop in the flush cycle SHALL be ignored; flush has priority over all.
REQ-024 flush_i SHALL be permitted to retract out_valid_o; the integrator issues flush only when the downstream crossing is idle.
REQ-025 Storage contents SHALL not require reset; only pointers and counter are reset.

Reset
REQ-026 On rst_i high at an edge: pointers=0, usage_o=0, empty_o=1, full_o=0, out_valid_o=0, in_ready_o=1 (when flush_i low).
REQ-027 Reset asserted mid-transfer SHALL drop all stored words and any pending out_valid_o within the same edge; rst_i overrides flush_i.

Configuration
REQ-028 Macro ISO_TX_FIFO_FALLTHROUGH_EN SHALL select zero-latency bypass.
REQ-029 With ISO_TX_FIFO_FALLTHROUGH_EN defined: when empty, out_valid_o=in_valid_i and out_data_o=in_data_i combinationally; if out_ready_i also high, the word passes without being stored (usage stays 0); otherwise it is stored and held per REQ-020.
REQ-030 With ISO_TX_FIFO_FALLTHROUGH_EN undefined: REQ-018/REQ-019 apply and no combinational path exists from in_* to out_*.

Verification
REQ-031 Reset: rst_i=1 two cycles with in_valid_i=1 -> usage_o=0, out_valid_o=0, empty_o=1 after release.
REQ-032 Fill: DEPTH=4, out_ready_i=0, push 0xA0..0xA3 -> full_o=1, in_ready_o=0, 5th word 0xA4 not accepted, out_data_o stays 0xA0.
REQ-033 Drain with wrap: after REQ-032, out_ready_i=1 while pushing 0xB0..0xB5 continuously -> output order 0xA0..0xA3,0xB0..0xB5, no loss, pointers wrap, usage_o never exceeds 4.
REQ-034 Stall stability: out_valid_o=1, data 0x55, out_ready_i=0 for 10 cycles -> out_valid_o and out_data_o constant 0x55 throughout.
REQ-035 Flush: usage_o=3, flush_i=1 with in_valid_i=1 and out_ready_i=1 -> next cycle usage_o=0, empty_o=1, no word pushed or popped.
REQ-036 Fallthrough: macro defined, empty, in_valid_i=1 data 0x7E, out_ready_i=1 -> out_data_o=0x7E same cycle, usage_o stays 0; macro undefined -> out_valid_o rises one cycle later.

Source files
------------

// File: rtl/iso_tx_fifo.sv
// Circular-buffer FIFO that feeds the source port of a downstream 4-phase clock-domain crossing.
// Define ISO_TX_FIFO_FALLTHROUGH_EN to pass words straight from in_* to out_* when the FIFO is empty.
module iso_tx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_WIDTH-1:0]      in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_WIDTH-1:0]      out_data_o,
  output logic [$clog2(DEPTH):0]     usage_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic push;
  logic pop;
  logic store_en;
  logic mem_pop;

  assign full_o     = (count == FULL_CNT);
  assign empty_o    = (count == '0);
  assign usage_o    = count;
  assign in_ready_o = !full_o && !flush_i;

  // NOTE: every output of a combinational block gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    out_valid_o = !empty_o;
    out_data_o  = mem[rd_ptr];
`ifdef ISO_TX_FIFO_FALLTHROUGH_EN
    if (empty_o) begin
      out_valid_o = in_valid_i && !flush_i;
      out_data_o  = in_data_i;
    end
`endif
  end

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

`ifdef ISO_TX_FIFO_FALLTHROUGH_EN
  // A word taken downstream while the FIFO is empty bypasses storage entirely.
  assign store_en = push && !(empty_o && out_ready_i);
  assign mem_pop  = pop && !empty_o;
`else
  assign store_en = push;
  assign mem_pop  = pop;
`endif

  // NOTE: payload storage has no reset; stale words are unreachable once the pointers and
  // counter are cleared, and leaving it out keeps the array a plain RAM.
  always_ff @(posedge clk_i) begin
    if (store_en) begin
      mem[wr_ptr] <= in_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (store_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (mem_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({store_en, mem_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
